// File: rtl/fadd_share_ctrl.sv
// fadd_share_ctrl: round-robin scheduler sharing one combinational fadd among NREQ requesters
module fadd_unit (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic [31:0] a, b;
    logic [23:0] ma, mb;
    logic [7:0]  d;
    logic [53:0] t;
    logic [26:0] ms, n;
    logic [27:0] s;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic signed [9:0] e, ef;
    logic        up, a_nan, a_inf, nan;
    always_comb begin
        a = (x2[30:0] > x1[30:0]) ? x2 : x1;
        b = (x2[30:0] > x1[30:0]) ? x1 : x2;
        ma = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        d = a[30:23] - b[30:23];
        t = {mb, 3'b000, 27'd0} >> ((d > 8'd27) ? 8'd27 : d);
        ms = {t[53:28], t[27] | (|t[26:0])};
        s = (a[31] == b[31]) ? {1'b0, ma, 3'b000} + {1'b0, ms} : {1'b0, ma, 3'b000} - {1'b0, ms};
        lz = 5'd0;
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
        e = s[27] ? $signed({2'b00, a[30:23]}) + 10'sd1 : $signed({2'b00, a[30:23]}) - $signed({5'd0, lz});
        up = n[2] & (n[1] | n[0] | n[3]);
        mr = {1'b0, n[26:3]} + {24'd0, up};
        ef = e + $signed({9'd0, mr[24]});
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        nan = a_nan || (a_inf && b[30:0] == a[30:0] && a[31] != b[31]);
        ovf = !nan && !a_inf && s != 28'd0 && ef >= 10'sd255;
        // subnormal results flush to signed zero
        y = nan ? 32'h7FC00000 :
            a_inf ? {a[31], 8'hFF, 23'd0} :
            (s == 28'd0) ? {a[31] & b[31], 31'd0} :
            ovf ? {a[31], 8'hFF, 23'd0} :
            (ef <= 10'sd0) ? {a[31], 31'd0} :
            {a[31], ef[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
endmodule

module fadd_share_ctrl #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [32*NREQ-1:0]  req_x1,
    input  logic [32*NREQ-1:0]  req_x2,
    input  logic [NREQ-1:0]     req_sub,
    input  logic                stall,
    output logic [NREQ-1:0]     res_valid,
    output logic [31:0]         res_y,
    output logic                res_ovf,
    output logic [NREQ-1:0]     ovf_sticky,
    input  logic [NREQ-1:0]     clr_sticky,
    output logic                busy
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0] ptr, gidx, t1;
    logic          found, acc, fo;
    logic [31:0]   x1r, x2r, fy;
    logic [LAT:1]  vs;
    logic [31:0]   py [2:LAT];
    logic          po [2:LAT];
    logic [PW-1:0] pt [2:LAT];
    always_comb begin
        gidx = '0;
        found = 1'b0;
        // descending scan so the nearest index after ptr wins
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                gidx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end
    assign acc = found && !stall && !rst;
    assign req_ready = acc ? NREQ'(1) << gidx : '0;
    assign res_valid = (vs[LAT] && !stall) ? NREQ'(1) << pt[LAT] : '0;
    assign res_y = py[LAT];
    assign res_ovf = po[LAT];
    assign busy = |vs;
    fadd_unit u_fadd (.x1(x1r), .x2(x2r), .y(fy), .ovf(fo));
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(NREQ - 1);
            vs <= '0;
            x1r <= '0;
            x2r <= '0;
            t1 <= '0;
            ovf_sticky <= '0;
            for (int j = 2; j <= LAT; j++) begin
                py[j] <= '0;
                po[j] <= 1'b0;
                pt[j] <= '0;
            end
        end else begin
            ovf_sticky <= (ovf_sticky & ~clr_sticky) | (res_valid & {NREQ{res_ovf}});
            if (!stall) begin
                vs <= {vs[LAT-1:1], acc};
                if (acc) begin
                    ptr <= gidx;
                    x1r <= req_x1[32*gidx +: 32];
                    x2r <= req_x2[32*gidx +: 32] ^ {req_sub[gidx], 31'd0};
                    t1 <= gidx;
                end
                if (vs[1]) begin
                    py[2] <= fy;
                    po[2] <= fo;
                    pt[2] <= t1;
                end
                for (int j = 3; j <= LAT; j++) begin
                    if (vs[j-1]) begin
                        py[j] <= py[j-1];
                        po[j] <= po[j-1];
                        pt[j] <= pt[j-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fadd_share_ctrl.sv
// tb_fadd_share_ctrl: directed checks of arbitration, latency, stall, sticky overflow and reset
module tb_fadd_share_ctrl;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
    logic [1:0]  req_valid = '0, req_sub = '0, clr_sticky = '0;
    logic [63:0] req_x1 = '0, req_x2 = '0;
    logic [1:0]  req_ready, res_valid, ovf_sticky;
    logic [31:0] res_y;
    logic        res_ovf, busy;
    int          n_chk = 0, n_fail = 0;
    int          p0 = 0, p1 = 0;
    logic [31:0] o0a [0:3] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000};
    logic [31:0] o0b [0:3] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40800000};
    logic [31:0] e0  [0:3] = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40E00000};
    logic [31:0] o1a [0:3] = '{32'h40800000, 32'h40000000, 32'h41000000, 32'hBF800000};
    logic [31:0] o1b [0:3] = '{32'h3F800000, 32'h3F000000, 32'h41000000, 32'h40400000};
    logic [31:0] e1  [0:3] = '{32'h40A00000, 32'h40200000, 32'h41800000, 32'h40000000};

    always #5 clk = ~clk;

    fadd_share_ctrl #(.NREQ(2), .LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub), .stall(stall),
        .res_valid(res_valid), .res_y(res_y), .res_ovf(res_ovf),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one isolated request from requester r, result checked LAT=2 cycles later
    task automatic single(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] ey, input logic eo, input logic [1:0] clr);
        @(negedge clk);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_sub = '0;
        req_sub[r] = sub;
        req_x1[32*r +: 32] = a;
        req_x2[32*r +: 32] = b;
        #1 chk("ready", req_ready, 32'(1 << r));
        @(negedge clk);
        req_valid = '0;
        #1 chk("busy_pend", busy, 1);
        chk("valid_pend", res_valid, 0);
        @(negedge clk);
        clr_sticky = clr;
        #1 chk("res_valid", res_valid, 32'(1 << r));
        chk("res_y", res_y, ey);
        chk("res_ovf", res_ovf, eo);
        chk("busy_res", busy, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1 chk("rst_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_sticky", ovf_sticky, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        rst = 1'b0;

        single(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 2'b00);
        single(1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 2'b00);

        req_sub = '0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            req_valid = {p1 < 4, p0 < 4};
            req_x1 = {o1a[p1 & 3], o0a[p0 & 3]};
            req_x2 = {o1b[p1 & 3], o0b[p0 & 3]};
            #1 chk("rr_ready", req_ready, (s < 8) ? 32'(1 << (s % 2)) : 32'd0);
            if (s >= 2) begin
                chk("rr_valid", res_valid, 32'(1 << ((s - 2) % 2)));
                chk("rr_y", res_y, ((s - 2) % 2 == 1) ? e1[(s - 2) / 2] : e0[(s - 2) / 2]);
            end
            if (s < 8) begin
                if (s % 2 == 0) p0++;
                else p1++;
            end
        end

        single(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 2'b00);
        @(negedge clk);
        #1 chk("sticky_set", ovf_sticky, 2'b01);
        single(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 2'b01);
        @(negedge clk);
        clr_sticky = '0;
        #1 chk("sticky_set_wins", ovf_sticky, 2'b01);
        @(negedge clk);
        clr_sticky = 2'b01;
        @(negedge clk);
        clr_sticky = '0;
        #1 chk("sticky_clr", ovf_sticky, 2'b00);

        @(negedge clk);
        req_valid = 2'b01;
        req_x1 = {32'h40000000, 32'h3F800000};
        req_x2 = {32'h40000000, 32'h3F800000};
        #1 chk("st_ready0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1 chk("st_ready1", req_ready, 2'b10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            req_valid = 2'b11;
            #1 chk("st_ready", req_ready, 0);
            chk("st_valid", res_valid, 0);
            chk("st_busy", busy, 1);
        end
        @(negedge clk);
        stall = 1'b0;
        req_valid = '0;
        #1 chk("st_rel_valid0", res_valid, 2'b01);
        chk("st_rel_y0", res_y, 32'h40000000);
        @(negedge clk);
        #1 chk("st_rel_valid1", res_valid, 2'b10);
        chk("st_rel_y1", res_y, 32'h40800000);
        @(negedge clk);
        #1 chk("st_done_valid", res_valid, 0);
        chk("st_done_busy", busy, 0);

        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        req_x1[31:0] = 32'h40400000;
        req_x2[31:0] = 32'h3F800000;
        #1 chk("mr_valid", res_valid, 0);
        chk("mr_y", res_y, 0);
        chk("mr_ovf", res_ovf, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        #1 chk("mr_flushed", res_valid, 0);
        chk("mr_busy1", busy, 1);
        @(negedge clk);
        #1 chk("mr_new_valid", res_valid, 2'b01);
        chk("mr_new_y", res_y, 32'h40800000);
        @(negedge clk);
        #1 chk("mr_end_valid", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
